// File: rtl/hazard_tracker_if.sv
// Bundle of decode-stage hazard inputs and the stall/forward controls returned to the pipeline.
interface hazard_tracker_if #(
    parameter int AW = 5,
    parameter int TW = 4
);
    logic [AW-1:0] HZT_i_RsD;
    logic [AW-1:0] HZT_i_RtD;
    logic [TW-1:0] HZT_i_TuseRsD;
    logic [TW-1:0] HZT_i_TuseRtD;
    logic [AW-1:0] HZT_i_RegWAddrD;
    logic [TW-1:0] HZT_i_TnewD;
    logic [1:0]    HZT_i_MdStartD;
    logic          HZT_i_MdUseD;
    logic          HZT_o_Stall;
    logic [1:0]    HZT_o_FwdRsD;
    logic [1:0]    HZT_o_FwdRtD;
    logic [1:0]    HZT_o_FwdRsE;
    logic [1:0]    HZT_o_FwdRtE;
    logic [1:0]    HZT_o_FwdRtM;
    logic          HZT_o_MdBusy;

    modport master (
        output HZT_i_RsD, HZT_i_RtD, HZT_i_TuseRsD, HZT_i_TuseRtD,
               HZT_i_RegWAddrD, HZT_i_TnewD, HZT_i_MdStartD, HZT_i_MdUseD,
        input  HZT_o_Stall, HZT_o_FwdRsD, HZT_o_FwdRtD, HZT_o_FwdRsE,
               HZT_o_FwdRtE, HZT_o_FwdRtM, HZT_o_MdBusy
    );

    modport slave (
        input  HZT_i_RsD, HZT_i_RtD, HZT_i_TuseRsD, HZT_i_TuseRtD,
               HZT_i_RegWAddrD, HZT_i_TnewD, HZT_i_MdStartD, HZT_i_MdUseD,
        output HZT_o_Stall, HZT_o_FwdRsD, HZT_o_FwdRtD, HZT_o_FwdRsE,
               HZT_o_FwdRtE, HZT_o_FwdRtM, HZT_o_MdBusy
    );
endinterface

// File: rtl/hazard_tracker.sv
// Tuse/Tnew hazard unit: shadows in-flight producers in E/M/W, drives the D stall,
// the D/E/M forwarding selects and the HI/LO multiply/divide busy counter.
module hazard_tracker #(
    parameter int                AW         = 5,
    parameter int                TW         = 4,
    parameter logic [TW-1:0]     TUSE_NEVER = {TW{1'b1}},
    parameter int                MUL_LAT    = 5,
    parameter int                DIV_LAT    = 10,
    parameter int                CW         = 4
) (
    input  logic             HZT_i_Clk,
    input  logic             HZT_i_Rst_n,
    hazard_tracker_if.slave  hzt
);

    logic [AW-1:0] r_addrE, r_rsE, r_rtE;
    logic [TW-1:0] r_tnewE;
    logic [1:0]    r_mdE;
    logic [AW-1:0] r_addrM, r_rtM;
    logic [TW-1:0] r_tnewM;
    logic [AW-1:0] r_addrW;
    logic [TW-1:0] r_tnewW;
    logic [CW-1:0] r_mdCnt;

    logic [AW-1:0] w_srcD  [2];
    logic [TW-1:0] w_tuseD [2];
    logic [AW-1:0] w_srcE  [2];
    logic [1:0]    w_fwdD  [2];
    logic [1:0]    w_fwdE  [2];
    logic [1:0]    w_hazD;
    logic [1:0]    w_fwdRtM;
    logic          w_mdBusy;
    logic          w_stall;

    function automatic logic [TW-1:0] f_satDec(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - TW'(1);
    endfunction

    assign w_srcD[0]  = hzt.HZT_i_RsD;
    assign w_srcD[1]  = hzt.HZT_i_RtD;
    assign w_tuseD[0] = hzt.HZT_i_TuseRsD;
    assign w_tuseD[1] = hzt.HZT_i_TuseRtD;
    assign w_srcE[0]  = r_rsE;
    assign w_srcE[1]  = r_rtE;

    // Only the nearest matching stage is consulted; an older producer is shadowed by a younger one.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_hazD[i] = 1'b0;
            w_fwdD[i] = 2'b00;
            if (w_srcD[i] != '0) begin
                if (w_srcD[i] == r_addrE) begin
                    w_hazD[i] = (w_tuseD[i] != TUSE_NEVER) && (r_tnewE > w_tuseD[i]);
                    w_fwdD[i] = (r_tnewE == '0) ? 2'b01 : 2'b00;
                end else if (w_srcD[i] == r_addrM) begin
                    w_hazD[i] = (w_tuseD[i] != TUSE_NEVER) && (r_tnewM > w_tuseD[i]);
                    w_fwdD[i] = (r_tnewM == '0) ? 2'b10 : 2'b00;
                end else if (w_srcD[i] == r_addrW) begin
                    w_hazD[i] = (w_tuseD[i] != TUSE_NEVER) && (r_tnewW > w_tuseD[i]);
                    w_fwdD[i] = (r_tnewW == '0) ? 2'b11 : 2'b00;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_fwdE[i] = 2'b00;
            if (w_srcE[i] != '0) begin
                if (w_srcE[i] == r_addrM) begin
                    w_fwdE[i] = (r_tnewM == '0) ? 2'b10 : 2'b00;
                end else if (w_srcE[i] == r_addrW && r_tnewW == '0) begin
                    w_fwdE[i] = 2'b11;
                end
            end
        end
        w_fwdRtM = ((r_rtM != '0) && (r_rtM == r_addrW) && (r_tnewW == '0)) ? 2'b11 : 2'b00;
    end

    assign w_mdBusy = (r_mdCnt != '0) || (r_mdE != 2'b00);
    assign w_stall  = (|w_hazD) || (hzt.HZT_i_MdUseD && w_mdBusy);

    assign hzt.HZT_o_Stall  = w_stall;
    assign hzt.HZT_o_FwdRsD = w_fwdD[0];
    assign hzt.HZT_o_FwdRtD = w_fwdD[1];
    assign hzt.HZT_o_FwdRsE = w_fwdE[0];
    assign hzt.HZT_o_FwdRtE = w_fwdE[1];
    assign hzt.HZT_o_FwdRtM = w_fwdRtM;
    assign hzt.HZT_o_MdBusy = w_mdBusy;

    // A stalled D instruction leaves a bubble in E while older producers keep draining.
    always_ff @(posedge HZT_i_Clk or negedge HZT_i_Rst_n) begin
        if (!HZT_i_Rst_n) begin
            r_addrE <= '0;
            r_tnewE <= '0;
            r_rsE   <= '0;
            r_rtE   <= '0;
            r_mdE   <= 2'b00;
            r_addrM <= '0;
            r_tnewM <= '0;
            r_rtM   <= '0;
            r_addrW <= '0;
            r_tnewW <= '0;
        end else begin
            if (w_stall) begin
                r_addrE <= '0;
                r_tnewE <= '0;
                r_rsE   <= '0;
                r_rtE   <= '0;
                r_mdE   <= 2'b00;
            end else begin
                r_addrE <= hzt.HZT_i_RegWAddrD;
                r_tnewE <= f_satDec(hzt.HZT_i_TnewD);
                r_rsE   <= hzt.HZT_i_RsD;
                r_rtE   <= hzt.HZT_i_RtD;
                r_mdE   <= hzt.HZT_i_MdStartD;
            end
            r_addrM <= r_addrE;
            r_tnewM <= f_satDec(r_tnewE);
            r_rtM   <= r_rtE;
            r_addrW <= r_addrM;
            r_tnewW <= f_satDec(r_tnewM);
        end
    end

    // The start in E reloads unconditionally, so a premature second start restarts the count.
    always_ff @(posedge HZT_i_Clk or negedge HZT_i_Rst_n) begin
        if (!HZT_i_Rst_n) begin
            r_mdCnt <= '0;
        end else begin
            case (r_mdE)
                2'b01:   r_mdCnt <= CW'(MUL_LAT);
                2'b10:   r_mdCnt <= CW'(DIV_LAT);
                default: if (r_mdCnt != '0) r_mdCnt <= r_mdCnt - CW'(1);
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Scenario bench for hazard_tracker: scripted instruction streams with per-cycle expected outputs.
module tb_hazard_tracker;

    localparam logic [3:0] NV = 4'hF;

    typedef struct {
        logic [4:0]  rs;
        logic [3:0]  tuRs;
        logic [4:0]  rt;
        logic [3:0]  tuRt;
        logic [4:0]  wa;
        logic [3:0]  tnew;
        logic [1:0]  md;
        logic        mdUse;
        logic [11:0] exp;
    } step_t;

    logic        clk;
    logic        rst_n;
    logic [11:0] obsVec;
    int          nCompared;
    int          nMismatched;
    step_t       stepQ[$];
    logic [11:0] expQ[$];

    hazard_tracker_if #(.AW(5), .TW(4)) hif();

    hazard_tracker dut (
        .HZT_i_Clk   (clk),
        .HZT_i_Rst_n (rst_n),
        .hzt         (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obsVec = {hif.HZT_o_Stall, hif.HZT_o_FwdRsD, hif.HZT_o_FwdRtD,
                     hif.HZT_o_FwdRsE, hif.HZT_o_FwdRtE, hif.HZT_o_FwdRtM, hif.HZT_o_MdBusy};

    function automatic logic [11:0] ex(input logic st, input logic [1:0] rsD, input logic [1:0] rtD,
                                       input logic [1:0] rsE, input logic [1:0] rtE,
                                       input logic [1:0] rtM, input logic busy);
        return {st, rsD, rtD, rsE, rtE, rtM, busy};
    endfunction

    function automatic step_t mkStep(input logic [4:0] rs, input logic [3:0] tuRs,
                                     input logic [4:0] rt, input logic [3:0] tuRt,
                                     input logic [4:0] wa, input logic [3:0] tnew,
                                     input logic [1:0] md, input logic mdUse,
                                     input logic [11:0] exp);
        step_t s;
        s.rs = rs; s.tuRs = tuRs; s.rt = rt; s.tuRt = tuRt;
        s.wa = wa; s.tnew = tnew; s.md = md; s.mdUse = mdUse; s.exp = exp;
        return s;
    endfunction

    task automatic applyStimulus(input step_t s);
        hif.HZT_i_RsD       = s.rs;
        hif.HZT_i_TuseRsD   = s.tuRs;
        hif.HZT_i_RtD       = s.rt;
        hif.HZT_i_TuseRtD   = s.tuRt;
        hif.HZT_i_RegWAddrD = s.wa;
        hif.HZT_i_TnewD     = s.tnew;
        hif.HZT_i_MdStartD  = s.md;
        hif.HZT_i_MdUseD    = s.mdUse;
    endtask

    task automatic pushNop();
        stepQ.push_back(mkStep(0, NV, 0, NV, 0, 0, 2'b00, 1'b0, 12'h000));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(mkStep(0, NV, 0, NV, 0, 0, 2'b00, 1'b0, 12'h000));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] want;
        rst_n = 1'b0;
        applyStimulus(mkStep(1, 0, 2, 0, 3, 3, 2'b10, 1'b1, 12'h000));
        expQ.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        want = expQ.pop_front();
        nCompared++;
        if (obsVec !== want) begin
            nMismatched++;
            $display("[TB] FAIL reset_held got %b want %b", obsVec, want);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(mkStep(0, NV, 0, NV, 0, 0, 2'b00, 1'b0, 12'h000));
        expQ.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        want = expQ.pop_front();
        nCompared++;
        if (obsVec !== want) begin
            nMismatched++;
            $display("[TB] FAIL reset_released got %b want %b", obsVec, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        step_t s;
        logic [11:0] want;
        int cyc = 0;
        doReset();
        stepQ.push_back(mkStep(2, 1, 0, NV, 1, 3, 2'b00, 1'b0, ex(0, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(1, 1, 1, 1, 2, 2, 2'b00, 1'b0, ex(1, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(1, 1, 1, 1, 2, 2, 2'b00, 1'b0, ex(0, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(0, NV, 0, NV, 0, 0, 2'b00, 1'b0, ex(0, 0, 0, 3, 3, 0, 0)));
        pushNop();
        while (stepQ.size() != 0) begin
            s = stepQ.pop_front();
            applyStimulus(s);
            expQ.push_back(s.exp);
            @(negedge clk);
            want = expQ.pop_front();
            nCompared++;
            if (obsVec !== want) begin
                nMismatched++;
                $display("[TB] FAIL load_use cyc%0d got %b want %b", cyc, obsVec, want);
            end
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_branch();
        step_t s;
        logic [11:0] want;
        int cyc = 0;
        doReset();
        stepQ.push_back(mkStep(2, 1, 0, NV, 1, 3, 2'b00, 1'b0, ex(0, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(1, 0, 0, 0, 0, 0, 2'b00, 1'b0, ex(1, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(1, 0, 0, 0, 0, 0, 2'b00, 1'b0, ex(1, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(1, 0, 0, 0, 0, 0, 2'b00, 1'b0, ex(0, 3, 0, 0, 0, 0, 0)));
        while (stepQ.size() != 0) begin
            s = stepQ.pop_front();
            applyStimulus(s);
            expQ.push_back(s.exp);
            @(negedge clk);
            want = expQ.pop_front();
            nCompared++;
            if (obsVec !== want) begin
                nMismatched++;
                $display("[TB] FAIL branch cyc%0d got %b want %b", cyc, obsVec, want);
            end
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_jal_jr();
        step_t s;
        logic [11:0] want;
        int cyc = 0;
        doReset();
        stepQ.push_back(mkStep(0, NV, 0, NV, 31, 1, 2'b00, 1'b0, ex(0, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(31, 0, 0, NV, 0, 0, 2'b00, 1'b0, ex(0, 1, 0, 0, 0, 0, 0)));
        while (stepQ.size() != 0) begin
            s = stepQ.pop_front();
            applyStimulus(s);
            expQ.push_back(s.exp);
            @(negedge clk);
            want = expQ.pop_front();
            nCompared++;
            if (obsVec !== want) begin
                nMismatched++;
                $display("[TB] FAIL jal_jr cyc%0d got %b want %b", cyc, obsVec, want);
            end
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_store();
        step_t s;
        logic [11:0] want;
        int cyc = 0;
        doReset();
        stepQ.push_back(mkStep(4, 1, 5, 1, 3, 2, 2'b00, 1'b0, ex(0, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(6, 1, 3, 2, 0, 0, 2'b00, 1'b0, ex(0, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(0, NV, 0, NV, 0, 0, 2'b00, 1'b0, ex(0, 0, 0, 0, 2, 0, 0)));
        stepQ.push_back(mkStep(0, NV, 0, NV, 0, 0, 2'b00, 1'b0, ex(0, 0, 0, 0, 0, 3, 0)));
        while (stepQ.size() != 0) begin
            s = stepQ.pop_front();
            applyStimulus(s);
            expQ.push_back(s.exp);
            @(negedge clk);
            want = expQ.pop_front();
            nCompared++;
            if (obsVec !== want) begin
                nMismatched++;
                $display("[TB] FAIL store cyc%0d got %b want %b", cyc, obsVec, want);
            end
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_md(input logic [1:0] md, input int busyCycles);
        step_t s;
        logic [11:0] want;
        int cyc = 0;
        doReset();
        stepQ.push_back(mkStep(8, 1, 9, 1, 0, 0, md, 1'b1, ex(0, 0, 0, 0, 0, 0, 0)));
        for (int i = 0; i < busyCycles + 1; i++)
            stepQ.push_back(mkStep(0, NV, 0, NV, 10, 2, 2'b00, 1'b1, ex(1, 0, 0, 0, 0, 0, 1)));
        stepQ.push_back(mkStep(0, NV, 0, NV, 10, 2, 2'b00, 1'b1, ex(0, 0, 0, 0, 0, 0, 0)));
        while (stepQ.size() != 0) begin
            s = stepQ.pop_front();
            applyStimulus(s);
            expQ.push_back(s.exp);
            @(negedge clk);
            want = expQ.pop_front();
            nCompared++;
            if (obsVec !== want) begin
                nMismatched++;
                $display("[TB] FAIL md%b cyc%0d got %b want %b", md, cyc, obsVec, want);
            end
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_reset_mid_div();
        step_t s;
        logic [11:0] want;
        int cyc = 0;
        doReset();
        stepQ.push_back(mkStep(2, 1, 0, NV, 1, 3, 2'b00, 1'b0, ex(0, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(8, 1, 9, 1, 0, 0, 2'b10, 1'b1, ex(0, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(1, 0, 0, NV, 0, 0, 2'b00, 1'b1, ex(1, 0, 0, 0, 0, 0, 1)));
        while (stepQ.size() != 0) begin
            s = stepQ.pop_front();
            applyStimulus(s);
            expQ.push_back(s.exp);
            @(negedge clk);
            want = expQ.pop_front();
            nCompared++;
            if (obsVec !== want) begin
                nMismatched++;
                $display("[TB] FAIL reset_mid cyc%0d got %b want %b", cyc, obsVec, want);
            end
            if (stepQ.size() != 0) begin
                @(posedge clk);
                #1 cyc++;
            end
        end
        #1 rst_n = 1'b0;
        expQ.push_back(ex(0, 0, 0, 0, 0, 0, 0));
        #1;
        want = expQ.pop_front();
        nCompared++;
        if (obsVec !== want) begin
            nMismatched++;
            $display("[TB] FAIL reset_mid_async got %b want %b", obsVec, want);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        stepQ.push_back(mkStep(1, 1, 1, 1, 2, 2, 2'b00, 1'b1, ex(0, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(1, 0, 0, NV, 0, 0, 2'b00, 1'b1, ex(0, 0, 0, 0, 0, 0, 0)));
        while (stepQ.size() != 0) begin
            s = stepQ.pop_front();
            applyStimulus(s);
            expQ.push_back(s.exp);
            @(negedge clk);
            want = expQ.pop_front();
            nCompared++;
            if (obsVec !== want) begin
                nMismatched++;
                $display("[TB] FAIL reset_mid_after cyc%0d got %b want %b", cyc, obsVec, want);
            end
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        logic [11:0] want;
        int cyc = 0;
        doReset();
        stepQ.push_back(mkStep(0, NV, 0, NV, 0, 3, 2'b00, 1'b0, ex(0, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(0, 0, 0, 0, 5, 3, 2'b00, 1'b0, ex(0, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(7, 0, 5, 1, 0, 0, 2'b00, 1'b0, ex(1, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(7, 0, 5, 1, 0, 0, 2'b00, 1'b0, ex(0, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(0, NV, 0, NV, 6, 3, 2'b00, 1'b0, ex(0, 0, 0, 0, 3, 0, 0)));
        stepQ.push_back(mkStep(0, NV, 0, NV, 6, 1, 2'b00, 1'b0, ex(0, 0, 0, 0, 0, 0, 0)));
        stepQ.push_back(mkStep(6, 0, 0, NV, 0, 0, 2'b00, 1'b0, ex(0, 1, 0, 0, 0, 0, 0)));
        while (stepQ.size() != 0) begin
            s = stepQ.pop_front();
            applyStimulus(s);
            expQ.push_back(s.exp);
            @(negedge clk);
            want = expQ.pop_front();
            nCompared++;
            if (obsVec !== want) begin
                nMismatched++;
                $display("[TB] FAIL back_to_back cyc%0d got %b want %b", cyc, obsVec, want);
            end
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst_n       = 1'b1;
        applyStimulus(mkStep(0, NV, 0, NV, 0, 0, 2'b00, 1'b0, 12'h000));
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_jal_jr();
        test_store();
        test_md(2'b01, 5);
        test_md(2'b10, 10);
        test_reset_mid_div();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
